wg_keystream_gen: RTL and testbench

- Parametrised Welch-Gong keystream generator built around an LFSR over GF(2^M).
- Feedback uses a constant gamma multiplier.
- Each output bit is the WG transform of the last LFSR stage.
- Has a load / nonlinear-init / run sequence and packs bits into W-bit words behind a valid/ready handshake.
- Generalises the fixed 5-bit gamma_mult/WGT blocks into a sequential source for the TRNG post-processing path.

---
 rtl/wg_pkg.sv | 20 ++
 rtl/wg_gf_mult.sv | 22 ++
 rtl/wg_keystream_gen.sv | 134 +++++++++++++
 tb/tb_wg_keystream_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wg_pkg.sv
// Shared types and sizing helpers for the Welch-Gong keystream generator.
package wg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } wg_state_e;

  localparam int WG_M      = 5;
  localparam int WG_L      = 32;
  localparam int WG_W      = 8;
  localparam int WG_SEED_W = WG_M * WG_L;

  // Collector bit-counter width; never narrower than one bit.
  function automatic int wg_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/wg_gf_mult.sv
// Combinational multiply by the constant GAMMA in GF(2^M) with POLY reduction.
module wg_gf_mult #(
  parameter int             M     = 5,
  parameter logic [M-1:0]   POLY  = 5'b00101,
  parameter logic [M-1:0]   GAMMA = 5'b01100
) (
  input  logic [M-1:0] i_x,
  output logic [M-1:0] o_y
);

  // Shift-and-add: accumulate x*alpha^j for each set bit j of GAMMA.
  always_comb begin
    logic [M-1:0] w_a;
    w_a = i_x;
    o_y = '0;
    for (int j = 0; j < M; j++) begin
      if (GAMMA[j]) o_y = o_y ^ w_a;
      w_a = {w_a[M-2:0], 1'b0} ^ ({M{w_a[M-1]}} & POLY);
    end
  end

endmodule

// File: rtl/wg_keystream_gen.sv
// Welch-Gong keystream generator: GF(2^M) LFSR, WG output filter, W-bit word packer.
module wg_keystream_gen
  import wg_pkg::*;
#(
  parameter int                M           = WG_M,
  parameter int                L           = WG_L,
  parameter logic [M-1:0]      POLY        = 5'b00101,
  parameter logic [M-1:0]      GAMMA       = 5'b01100,
  parameter logic [L-1:0]      TAP_MASK    = 32'h0000_0102,
  parameter logic [2**M-1:0]   WGT_LUT     = 32'hD3A6_8E15,
  parameter int                INIT_CYCLES = 64,
  parameter int                W           = WG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [L*M-1:0]   seed_i,
  output logic [W-1:0]     ks_data_o,
  output logic             ks_valid_o,
  input  logic             ks_ready_i,
  output logic             busy_o,
  output logic             seed_zero_o
);

  localparam int            CW        = wg_cnt_w(W);
  localparam int            IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [IW-1:0] ICNT_LAST = IW'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_LAST  = CW'(W - 1);

  wg_state_e               r_state, w_state_nxt;
  logic [L-1:0][M-1:0]     r_s;
  logic [IW-1:0]           r_icnt;
  logic [CW-1:0]           r_cnt;
  logic [W-1:0]            r_col;
  logic [W-1:0]            r_data;
  logic                    r_valid, r_busy, r_seed_zero;
  logic [M-1:0]            w_g, w_f;
  logic                    w_z, w_step, w_inject, w_word_done;

  wg_gf_mult #(.M(M), .POLY(POLY), .GAMMA(GAMMA)) u_gmul (
    .i_x (r_s[0]),
    .o_y (w_g)
  );

  assign w_z = WGT_LUT[r_s[L-1]];

  // Linear feedback: gamma*s[0] plus every tapped stage.
  always_comb begin
    w_f = w_g;
    for (int i = 0; i < L; i++)
      if (TAP_MASK[i]) w_f = w_f ^ r_s[i];
  end

  // State and busy registers; busy mirrors the state it will be in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next state: load wins everywhere; INIT ends after INIT_CYCLES steps.
  always_comb begin
    w_state_nxt = r_state;
    if (load_i)
      w_state_nxt = (INIT_CYCLES == 0) ? ST_RUN : ST_INIT;
    else if (r_state == ST_INIT && r_icnt == ICNT_LAST)
      w_state_nxt = ST_RUN;
  end

  // Step control: INIT always steps with z injected, RUN steps unless a word is stalled.
  always_comb begin
    w_step   = 1'b0;
    w_inject = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        w_step   = 1'b1;
        w_inject = 1'b1;
      end
      ST_RUN:  w_step = !r_valid || ks_ready_i;
      default: ;
    endcase
  end

  assign w_word_done = w_step && !w_inject && (r_cnt == CNT_LAST);

  // LFSR, init counter, bit collector and output word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_icnt      <= '0;
      r_cnt       <= '0;
      r_col       <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_seed_zero <= 1'b0;
    end else if (load_i) begin
      // Reload drops any partial or pending word.
      r_s         <= seed_i;
      r_icnt      <= '0;
      r_cnt       <= '0;
      r_col       <= '0;
      r_valid     <= 1'b0;
      r_seed_zero <= (seed_i == '0);
    end else begin
      if (w_step) begin
        r_s <= {w_f ^ {{(M-1){1'b0}}, w_inject & w_z}, r_s[L-1:1]};
        if (w_inject) begin
          r_icnt <= r_icnt + 1'b1;
        end else begin
          r_col[r_cnt] <= w_z;
          if (w_word_done) begin
            r_data <= {w_z, r_col[W-2:0]};
            r_cnt  <= '0;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
          end
        end
      end
      // A completed word overrides the acceptance of the previous one.
      if (w_word_done)     r_valid <= 1'b1;
      else if (ks_ready_i) r_valid <= 1'b0;
    end
  end

  assign ks_data_o   = r_data;
  assign ks_valid_o  = r_valid;
  assign busy_o      = r_busy;
  assign seed_zero_o = r_seed_zero;

endmodule

// File: tb/tb_wg_keystream_gen.sv
// Self-checking bench for wg_keystream_gen against an arithmetic WG reference model.
module tb_wg_keystream_gen;

  localparam int          M        = 5;
  localparam int          L        = 32;
  localparam int          POLY     = 5'b00101;
  localparam int          GAMMA    = 5'b01100;
  localparam logic [31:0] TAPS     = 32'h0000_0102;
  localparam logic [31:0] LUT_DEF  = 32'hD3A6_8E15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic load_a = 0, ready_a = 0, valid_a, busy_a, sz_a;
  logic [L*M-1:0] seed_a = '0;
  logic [7:0] data_a;
  // Instance B: all-ones LUT, 4 init rounds
  logic load_b = 0, ready_b = 0, valid_b, busy_b, sz_b;
  logic [L*M-1:0] seed_b = '0;
  logic [7:0] data_b;
  // Instance C: no init rounds, LUT bit0 cleared
  logic load_c = 0, ready_c = 0, valid_c, busy_c, sz_c;
  logic [L*M-1:0] seed_c = '0;
  logic [7:0] data_c;
  // Standalone multiplier
  logic [4:0] gx = '0, gy;

  wg_keystream_gen dut_a (
    .clk(clk), .rst_n(rst_n), .load_i(load_a), .seed_i(seed_a), .ks_data_o(data_a),
    .ks_valid_o(valid_a), .ks_ready_i(ready_a), .busy_o(busy_a), .seed_zero_o(sz_a));

  wg_keystream_gen #(.WGT_LUT(32'hFFFF_FFFF), .INIT_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_i(load_b), .seed_i(seed_b), .ks_data_o(data_b),
    .ks_valid_o(valid_b), .ks_ready_i(ready_b), .busy_o(busy_b), .seed_zero_o(sz_b));

  wg_keystream_gen #(.WGT_LUT(32'hD3A6_8E14), .INIT_CYCLES(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .load_i(load_c), .seed_i(seed_c), .ks_data_o(data_c),
    .ks_valid_o(valid_c), .ks_ready_i(ready_c), .busy_o(busy_c), .seed_zero_o(sz_c));

  wg_gf_mult u_gf (.i_x(gx), .o_y(gy));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  int ms[L];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Polynomial product, then reduction by x^M + POLY from the top bit down.
  function automatic int gmul(input int x);
    int p = 0;
    for (int i = 0; i < M; i++)
      if (((GAMMA >> i) & 1) != 0) p ^= x << i;
    for (int k = 2*M-2; k >= M; k--)
      if (((p >> k) & 1) != 0) p ^= ((1 << M) | POLY) << (k - M);
    return p;
  endfunction

  // One register step of the reference; returns the filter output of the last stage.
  function automatic int mstep(input logic [31:0] lut, input bit init);
    int z, f;
    z = lut[ms[L-1]] ? 1 : 0;
    f = gmul(ms[0]);
    for (int i = 0; i < L; i++) if (TAPS[i]) f ^= ms[i];
    for (int i = 0; i < L-1; i++) ms[i] = ms[i+1];
    ms[L-1] = init ? (f ^ z) : f;
    return z;
  endfunction

  task automatic gen_words(input logic [L*M-1:0] seed, input logic [31:0] lut,
                           input int ninit, input int nw);
    logic [7:0] wd;
    exp_q.delete();
    for (int i = 0; i < L; i++) ms[i] = int'(seed[i*M +: M]);
    for (int c = 0; c < ninit; c++) void'(mstep(lut, 1'b1));
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < 8; b++) wd[b] = mstep(lut, 1'b0) != 0;
      exp_q.push_back(wd);
    end
  endtask

  function automatic logic [L*M-1:0] rand_seed();
    logic [L*M-1:0] s;
    for (int i = 0; i < L*M; i += 32) s[i +: 32] = $urandom;
    s[0] = 1'b1;
    return s;
  endfunction

  task automatic wait_valid_a(input int maxc);
    int c = 0;
    @(negedge clk);
    while (!valid_a && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (!valid_a) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic consume_a(input int nw, input int pct);
    int got = 0;
    int cyc = 0;
    while (got < nw && cyc < nw*40 + 200) begin
      @(posedge clk);
      #1 ready_a = ($urandom_range(99) < pct);
      @(negedge clk);
      cyc++;
      if (valid_a && ready_a) begin
        chk("word", data_a, exp_q.pop_front());
        got++;
      end
    end
    if (got < nw) chk("consume_timeout", got, nw);
    @(posedge clk);
    #1 ready_a = 1'b0;
  endtask

  initial begin
    logic [L*M-1:0] s1, s2;
    int nw;

    // Multiplier corner values
    gx = 5'b00001; #1 chk("gf_1", gy, 5'b01100);
    gx = 5'b00010; #1 chk("gf_2", gy, 5'b11000);
    gx = 5'b10101; #1 chk("gf_21", gy, 5'b00111);

    // Reset values
    #10;
    chk("rst_valid", valid_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_sz", sz_a, 0);
    @(negedge clk); rst_n = 1'b1;

    // All-ones LUT: every word 8'hFF, first valid after t+12, then every 8
    @(posedge clk);
    #1 begin load_b = 1'b1; seed_b = rand_seed(); ready_b = 1'b1; end
    @(posedge clk);
    #1 load_b = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1) chk("b_busy", busy_b, 1);
      chk("b_valid", valid_b, (k >= 12 && (k - 12) % 8 == 0));
      if (valid_b) chk("b_data", data_b, 8'hFF);
    end

    // Zero seed, no init rounds: register stays zero, every word zero
    @(posedge clk);
    #1 begin load_c = 1'b1; seed_c = '0; ready_c = 1'b1; end
    @(posedge clk);
    #1 load_c = 1'b0;
    nw = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 1) chk("c_seed_zero", sz_c, 1);
      if (k == 8) chk("c_first_valid", valid_c, 1);
      if (valid_c) begin
        chk("c_data", data_c, 0);
        nw++;
      end
    end
    chk("c_words", (nw >= 4), 1);

    // Backpressure: hold a finished word for 20 cycles, then random ready
    s1 = rand_seed();
    @(posedge clk);
    #1 begin load_a = 1'b1; seed_a = s1; ready_a = 1'b0; end
    @(posedge clk);
    #1 load_a = 1'b0;
    gen_words(s1, LUT_DEF, 64, 1000);
    @(negedge clk);
    chk("a_seed_zero", sz_a, 0);
    chk("a_busy", busy_a, 1);
    wait_valid_a(200);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("stall_valid", valid_a, 1);
      chk("stall_data", data_a, exp_q[0]);
    end
    consume_a(1000, 60);

    // Reload while a word is pending
    wait_valid_a(40);
    s2 = rand_seed();
    @(posedge clk);
    #1 begin load_a = 1'b1; seed_a = s2; end
    @(posedge clk);
    #1 load_a = 1'b0;
    gen_words(s2, LUT_DEF, 64, 6);
    @(negedge clk);
    chk("reload_drop", valid_a, 0);
    for (int k = 1; k <= 72; k++) begin
      @(posedge clk); @(negedge clk);
      chk("reload_lat", valid_a, (k == 72));
    end
    chk("reload_first", data_a, exp_q[0]);
    consume_a(6, 100);

    // Asynchronous reset between edges
    wait_valid_a(40);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", valid_a, 0);
    chk("arst_data", data_a, 0);
    chk("arst_busy", busy_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
